my_fft_n4: RTL

Streaming 4-point radix-2 DIT FFT for the FFT datapath; the next generation of the 2-point butterfly. It accepts one complex sample per clock in frames of four, marked by a first-word flag. It emits the four bins in natural order, one per clock, with full bit growth or an optional per-frame divide-by-4. It supports gapless back-to-back frames and detects truncated frames.

---
 rtl/my_fft_n4_if.sv | 36 +++
 rtl/my_fft_n4.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/my_fft_n4_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_fft_n4_if
//  Description : Sample/bin bus of the streaming 4-point FFT. The master
//                side supplies framed complex samples, the slave side returns
//                the four bins of each frame plus the truncated-frame pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface my_fft_n4_if #(
  parameter int DATA_WIDTH = 32
);

  logic                         data_in_flag_i;
  logic signed [DATA_WIDTH-1:0] xn_real_i;
  logic signed [DATA_WIDTH-1:0] xn_imag_i;
  logic                         scale_i;
  logic                         data_out_flag_o;
  logic                         data_out_valid_o;
  logic signed [DATA_WIDTH+1:0] xk_real_o;
  logic signed [DATA_WIDTH+1:0] xk_imag_o;
  logic                         frame_err_o;

  // Sample source / bin sink
  modport master (
    output data_in_flag_i, xn_real_i, xn_imag_i, scale_i,
    input  data_out_flag_o, data_out_valid_o, xk_real_o, xk_imag_o, frame_err_o
  );

  // FFT core
  modport slave (
    input  data_in_flag_i, xn_real_i, xn_imag_i, scale_i,
    output data_out_flag_o, data_out_valid_o, xk_real_o, xk_imag_o, frame_err_o
  );

endinterface
`default_nettype wire

// File: rtl/my_fft_n4.sv
`default_nettype none
// ============================================================================
//  Module      : my_fft_n4
//  Description : Streaming 4-point radix-2 DIT FFT. One complex sample per
//                clock, frames of four marked by a first-word flag, bins out
//                in natural order with full bit growth or optional /4.
//                Truncated frames are discarded and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module my_fft_n4 #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic    sys_clk_i,
  input  wire logic    sys_rst_i,
  my_fft_n4_if.slave   bus
);

  localparam int c_stage1_w = DATA_WIDTH + 1;
  localparam int c_stage2_w = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_S3   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_take_x0;
  logic   w_take_x1;
  logic   w_take_x2;
  logic   w_take_x3;
  logic   w_err;

  // Captured samples x0..x2 of the frame in progress (x3 is used live)
  logic signed [DATA_WIDTH-1:0] r_x_re [3];
  logic signed [DATA_WIDTH-1:0] r_x_im [3];
  logic                         r_scale_in;

  // Stage-1 butterflies of the completed frame
  logic signed [c_stage1_w-1:0] r_a_re [4];
  logic signed [c_stage1_w-1:0] r_a_im [4];
  logic                         r_a_scale;
  logic                         r_a_valid;

  // Stage-2 results, before and after optional scaling
  logic signed [c_stage2_w-1:0] w_x_re [4];
  logic signed [c_stage2_w-1:0] w_x_im [4];
  logic signed [c_stage2_w-1:0] w_s_re [4];
  logic signed [c_stage2_w-1:0] w_s_im [4];

  // Output buffer drained X0..X3
  logic signed [c_stage2_w-1:0] r_buf_re [4];
  logic signed [c_stage2_w-1:0] r_buf_im [4];
  logic [1:0]                   r_out_idx;
  logic                         r_out_valid;
  logic                         r_frame_err;

  function automatic logic signed [c_stage1_w-1:0] ext1(input logic signed [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-1], v};
  endfunction

  function automatic logic signed [c_stage2_w-1:0] ext2(input logic signed [c_stage1_w-1:0] v);
    return {v[c_stage1_w-1], v};
  endfunction

  // Input sample counter state register
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Next state and per-sample capture strobes; a flag in S1/S2 restarts the frame
  always_comb begin
    w_state_nxt = r_state;
    w_take_x0   = 1'b0;
    w_take_x1   = 1'b0;
    w_take_x2   = 1'b0;
    w_take_x3   = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.data_in_flag_i) begin
          w_take_x0   = 1'b1;
          w_state_nxt = ST_S1;
        end
      end
      ST_S1: begin
        if (bus.data_in_flag_i) begin
          w_err       = 1'b1;
          w_take_x0   = 1'b1;
          w_state_nxt = ST_S1;
        end else begin
          w_take_x1   = 1'b1;
          w_state_nxt = ST_S2;
        end
      end
      ST_S2: begin
        if (bus.data_in_flag_i) begin
          w_err       = 1'b1;
          w_take_x0   = 1'b1;
          w_state_nxt = ST_S1;
        end else begin
          w_take_x2   = 1'b1;
          w_state_nxt = ST_S3;
        end
      end
      ST_S3: begin
        // x3 always completes the frame; a flag here also opens the next one
        w_take_x3 = 1'b1;
        if (bus.data_in_flag_i) begin
          w_take_x0   = 1'b1;
          w_state_nxt = ST_S1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sample capture; the frame scale is latched only with the flagged word
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      for (int k = 0; k < 3; k++) begin
        r_x_re[k] <= '0;
        r_x_im[k] <= '0;
      end
      r_scale_in <= 1'b0;
    end else begin
      if (w_take_x0) begin
        r_x_re[0]  <= bus.xn_real_i;
        r_x_im[0]  <= bus.xn_imag_i;
        r_scale_in <= bus.scale_i;
      end
      if (w_take_x1) begin
        r_x_re[1] <= bus.xn_real_i;
        r_x_im[1] <= bus.xn_imag_i;
      end
      if (w_take_x2) begin
        r_x_re[2] <= bus.xn_real_i;
        r_x_im[2] <= bus.xn_imag_i;
      end
    end
  end

  // Stage-1 butterflies loaded on the edge that takes x3
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      for (int k = 0; k < 4; k++) begin
        r_a_re[k] <= '0;
        r_a_im[k] <= '0;
      end
      r_a_scale <= 1'b0;
      r_a_valid <= 1'b0;
    end else begin
      r_a_valid <= w_take_x3;
      if (w_take_x3) begin
        r_a_re[0] <= ext1(r_x_re[0]) + ext1(r_x_re[2]);
        r_a_im[0] <= ext1(r_x_im[0]) + ext1(r_x_im[2]);
        r_a_re[1] <= ext1(r_x_re[0]) - ext1(r_x_re[2]);
        r_a_im[1] <= ext1(r_x_im[0]) - ext1(r_x_im[2]);
        r_a_re[2] <= ext1(r_x_re[1]) + ext1(bus.xn_real_i);
        r_a_im[2] <= ext1(r_x_im[1]) + ext1(bus.xn_imag_i);
        r_a_re[3] <= ext1(r_x_re[1]) - ext1(bus.xn_real_i);
        r_a_im[3] <= ext1(r_x_im[1]) - ext1(bus.xn_imag_i);
        r_a_scale <= r_scale_in;
      end
    end
  end

  // Stage-2 butterflies with the -j twiddle folded into swaps, then optional floor /4
  always_comb begin
    w_x_re[0] = ext2(r_a_re[0]) + ext2(r_a_re[2]);
    w_x_im[0] = ext2(r_a_im[0]) + ext2(r_a_im[2]);
    w_x_re[2] = ext2(r_a_re[0]) - ext2(r_a_re[2]);
    w_x_im[2] = ext2(r_a_im[0]) - ext2(r_a_im[2]);
    w_x_re[1] = ext2(r_a_re[1]) + ext2(r_a_im[3]);
    w_x_im[1] = ext2(r_a_im[1]) - ext2(r_a_re[3]);
    w_x_re[3] = ext2(r_a_re[1]) - ext2(r_a_im[3]);
    w_x_im[3] = ext2(r_a_im[1]) + ext2(r_a_re[3]);
    for (int k = 0; k < 4; k++) begin
      w_s_re[k] = r_a_scale ? (w_x_re[k] >>> 2) : w_x_re[k];
      w_s_im[k] = r_a_scale ? (w_x_im[k] >>> 2) : w_x_im[k];
    end
  end

  // Output buffer: a new frame reloads it, otherwise it drains one bin per clock
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      for (int k = 0; k < 4; k++) begin
        r_buf_re[k] <= '0;
        r_buf_im[k] <= '0;
      end
      r_out_idx   <= 2'd0;
      r_out_valid <= 1'b0;
    end else if (r_a_valid) begin
      for (int k = 0; k < 4; k++) begin
        r_buf_re[k] <= w_s_re[k];
        r_buf_im[k] <= w_s_im[k];
      end
      r_out_idx   <= 2'd0;
      r_out_valid <= 1'b1;
    end else if (r_out_valid) begin
      if (r_out_idx == 2'd3) r_out_valid <= 1'b0;
      r_out_idx <= r_out_idx + 2'd1;
    end
  end

  // Truncated-frame pulse, one cycle after the offending edge
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) r_frame_err <= 1'b0;
    else           r_frame_err <= w_err;
  end

  assign bus.data_out_valid_o = r_out_valid;
  assign bus.data_out_flag_o  = r_out_valid && (r_out_idx == 2'd0);
  assign bus.xk_real_o        = r_out_valid ? r_buf_re[r_out_idx] : '0;
  assign bus.xk_imag_o        = r_out_valid ? r_buf_im[r_out_idx] : '0;
  assign bus.frame_err_o      = r_frame_err;

endmodule
`default_nettype wire
